mouse_packet: RTL and testbench
===============================

MOUSE_PACKET -- requirements
Module: mouse_packet

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1250000, meaning the maximum clocks allowed between bytes of one packet (25 ms at 50 MHz).
REQ-002 SHALL have parameter DAV_CYCLES, default 4, meaning the number of clocks dav is held high per published packet.
REQ-003 SHALL have port clock  in  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port rxbyte  in  8  received PS/2 byte from the upstream receiver, valid when rxvalid=1.
REQ-006 SHALL have port rxvalid  in  1  one-clock strobe marking a new rxbyte.
REQ-007 SHALL have port rxerror  in  1  one-clock strobe for a parity or framing error on the current byte.
REQ-008 SHALL have port button  out  2  [0]=left, [1]=right, taken from byte0 bits 0 and 1.
REQ-009 SHALL have port sign  out  2  [0]=Y sign (byte0 bit5), [1]=X sign (byte0 bit4).
REQ-010 SHALL have port mousexdata  out  8  X movement, low 8 bits of the 9-bit two's-complement value.
REQ-011 SHALL have port mouseydata  out  8  Y movement, low 8 bits of the 9-bit two's-complement value.
REQ-012 SHALL have port dav  out  1  packet-available level, high for DAV_CYCLES clocks per packet.
REQ-013 SHALL have port perr  out  1  one-clock strobe when a packet is discarded.

Function
REQ-014 SHALL implement the states IDLE_B0, GET_B1 and GET_B2.
REQ-015 In IDLE_B0, rxvalid with rxbyte bit3=1 SHALL latch byte0 and go to GET_B1.
REQ-016 In IDLE_B0, rxvalid with rxbyte bit3=0 SHALL discard the byte, stay in IDLE_B0 and pulse perr (resync).
REQ-017 In GET_B1, rxvalid SHALL latch the X byte and go to GET_B2.
REQ-018 In GET_B2, rxvalid SHALL complete the packet, update outputs the next clock, and return to IDLE_B0.
REQ-019 rxerror in any state SHALL discard the partial packet, return to IDLE_B0 and pulse perr; rxerror takes priority over a simultaneous rxvalid.
REQ-020 In GET_B1 or GET_B2, a gap counter SHALL count clocks since the last accepted byte; reaching TIMEOUT_CYCLES SHALL return to IDLE_B0 and pulse perr.
REQ-021 The gap counter SHALL clear on every accepted byte and hold at 0 in IDLE_B0.
REQ-022 Outputs button, sign, mousexdata and mouseydata SHALL update only on packet completion and hold stable between packets.
REQ-023 X overflow (byte0 bit6=1) SHALL force mousexdata to 8'hFF when the sign is 0, and to 8'h01 when the sign is 1 (magnitude 255).
REQ-024 Y overflow (byte0 bit7=1) SHALL force mouseydata in the same way, using the Y sign.
REQ-025 A data byte of 8'h00 with its sign=1 (value -256) SHALL be output as 8'h01.
REQ-026 dav SHALL rise in the same clock as the output update and stay high exactly DAV_CYCLES clocks; data is stable for the whole high period.
REQ-027 A packet completing while dav is high SHALL update the outputs, hold dav low for one clock, then reassert dav for DAV_CYCLES clocks, so the consumer sees a fresh rising edge.
REQ-028 Completion-to-dav latency SHALL be 1 clock after the rxvalid of byte2.
REQ-029 perr SHALL not affect the held outputs or a dav period in progress.

Reset
REQ-030 Reset SHALL set the state to IDLE_B0 and clear the gap counter.
REQ-031 Reset SHALL drive button=0, sign=0, mousexdata=0, mouseydata=0, dav=0 and perr=0.
REQ-032 Reset asserted mid-packet or during dav high SHALL abort immediately; dav SHALL be 0 the clock after reset is sampled.
REQ-033 rxvalid coincident with reset SHALL be ignored.

Verification
REQ-034 Bytes 08,05,FD -> button=00, sign=00, mousexdata=05, mouseydata=FD, dav high for 4 clocks starting 1 clock after byte2.
REQ-035 Bytes 39,FB,02 -> button=01, sign=11, mousexdata=FB, mouseydata=02; then bytes 03,08,05,FD -> perr pulse on 03, then a normal packet.
REQ-036 Bytes 58,00,10 -> mousexdata=01 (X overflow, negative), mouseydata=10, sign[1]=1.
REQ-037 Bytes 08,05 then no byte for TIMEOUT_CYCLES clocks -> perr pulse; next bytes 08,01,01 decode as a fresh packet.
REQ-038 rxerror on byte1 -> perr, outputs unchanged, no dav; two back-to-back packets with DAV_CYCLES=4 -> dav low one clock between the two high periods.
REQ-039 Reset asserted during GET_B2 -> all outputs 0 next clock; a following full packet decodes correctly.

Source files
------------

// File: rtl/mouse_packet.sv
// PS/2 mouse packet assembler: collects the three-byte movement packet, decodes
// buttons/signs/movement with overflow saturation, and publishes it with a dav level.
module mouse_packet #(
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int DAV_CYCLES     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rxbyte,
  input  logic       rxvalid,
  input  logic       rxerror,
  output logic [1:0] button,
  output logic [1:0] sign,
  output logic [7:0] mousexdata,
  output logic [7:0] mouseydata,
  output logic       dav,
  output logic       perr
);

  localparam logic [1:0] IDLE_B0 = 2'd0;
  localparam logic [1:0] GET_B1  = 2'd1;
  localparam logic [1:0] GET_B2  = 2'd2;

  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(DAV_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DAV_LAST = DW'(DAV_CYCLES - 1);

  logic [1:0]    r_state;
  logic [GW-1:0] r_gap;
  // Header byte kept as {yOvf, xOvf, ySign, xSign, right, left}
  logic [5:0]    r_hdr;
  logic [7:0]    r_xByte;
  logic [DW-1:0] r_davCnt;
  logic          r_davPending;

  logic       w_complete;
  logic [7:0] w_xOut;
  logic [7:0] w_yOut;

  assign w_complete = (r_state == GET_B2) && rxvalid && !rxerror;

  // Overflow saturates to magnitude 255; the unrepresentable -256 also becomes -255
  always_comb begin
    w_xOut = r_xByte;
    if (r_hdr[4])
      w_xOut = r_hdr[2] ? 8'h01 : 8'hFF;
    else if (r_hdr[2] && (r_xByte == 8'h00))
      w_xOut = 8'h01;

    w_yOut = rxbyte;
    if (r_hdr[5])
      w_yOut = r_hdr[3] ? 8'h01 : 8'hFF;
    else if (r_hdr[3] && (rxbyte == 8'h00))
      w_yOut = 8'h01;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE_B0;
      r_gap   <= '0;
      r_hdr   <= '0;
      r_xByte <= '0;
      perr    <= 1'b0;
    end else begin
      perr <= 1'b0;
      if (rxerror) begin
        r_state <= IDLE_B0;
        r_gap   <= '0;
        perr    <= 1'b1;
      end else begin
        case (r_state)
          IDLE_B0: begin
            r_gap <= '0;
            if (rxvalid) begin
              if (rxbyte[3]) begin
                r_hdr   <= {rxbyte[7:4], rxbyte[1:0]};
                r_state <= GET_B1;
              end else begin
                perr <= 1'b1;
              end
            end
          end
          GET_B1, GET_B2: begin
            if (rxvalid) begin
              r_gap <= '0;
              if (r_state == GET_B1) begin
                r_xByte <= rxbyte;
                r_state <= GET_B2;
              end else begin
                r_state <= IDLE_B0;
              end
            end else if (r_gap == GAP_LAST) begin
              r_gap   <= '0;
              r_state <= IDLE_B0;
              perr    <= 1'b1;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE_B0;
            r_gap   <= '0;
          end
        endcase
      end
    end
  end

  // A packet landing while dav is high drops dav for one clock so the consumer sees a new edge
  always_ff @(posedge clock) begin
    if (reset) begin
      button       <= '0;
      sign         <= '0;
      mousexdata   <= '0;
      mouseydata   <= '0;
      dav          <= 1'b0;
      r_davCnt     <= '0;
      r_davPending <= 1'b0;
    end else begin
      if (w_complete) begin
        button     <= r_hdr[1:0];
        sign       <= {r_hdr[2], r_hdr[3]};
        mousexdata <= w_xOut;
        mouseydata <= w_yOut;
      end
      if (w_complete && dav) begin
        dav          <= 1'b0;
        r_davPending <= 1'b1;
      end else if (w_complete || r_davPending) begin
        dav          <= 1'b1;
        r_davCnt     <= DAV_LAST;
        r_davPending <= 1'b0;
      end else if (dav) begin
        if (r_davCnt == '0)
          dav <= 1'b0;
        else
          r_davCnt <= r_davCnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet.sv
// Bench for mouse_packet: spec vector table, directed corner sequences and
// randomized traffic checked every clock against a cycle-numbered reference model.
module tb_mouse_packet;

  localparam int TIMEOUT = 40;
  localparam int DAV     = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rxbyte;
  logic       rxvalid;
  logic       rxerror;
  logic [1:0] button;
  logic [1:0] sign;
  logic [7:0] mousexdata;
  logic [7:0] mouseydata;
  logic       dav;
  logic       perr;

  mouse_packet #(.TIMEOUT_CYCLES(TIMEOUT), .DAV_CYCLES(DAV)) dut (
    .clock(clock), .reset(reset), .rxbyte(rxbyte), .rxvalid(rxvalid), .rxerror(rxerror),
    .button(button), .sign(sign), .mousexdata(mousexdata), .mouseydata(mouseydata),
    .dav(dav), .perr(perr)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: bytes of the partial packet, cycle of last accepted byte, dav window
  logic [7:0] pkt[$];
  int         lastByte = 0;
  logic [1:0] mBtn = '0, mSign = '0;
  logic [7:0] mX = '0, mY = '0;
  logic       mPerr = 1'b0;
  int         davStart = -1, davEnd = -2;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [1:0] btn, sgn;
    logic [7:0] x, y;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [7:0] axis(input logic [7:0] b, input logic s, input logic ovf);
    int v;
    v = int'(b) - (s ? 256 : 0);
    if (ovf) v = s ? -255 : 255;
    if (v < -255) v = -255;
    return v[7:0];
  endfunction

  task automatic modelStep(input logic r, input logic v, input logic e, input logic [7:0] b);
    logic       prevDav;
    logic [7:0] h;
    prevDav = (cyc - 1 >= davStart) && (cyc - 1 <= davEnd);
    mPerr = 1'b0;
    if (r) begin
      pkt.delete();
      mBtn = '0; mSign = '0; mX = '0; mY = '0;
      davStart = -1; davEnd = -2;
    end else if (e) begin
      pkt.delete();
      mPerr = 1'b1;
    end else if (v) begin
      if (pkt.size() == 0 && !b[3]) begin
        mPerr = 1'b1;
      end else begin
        pkt.push_back(b);
        lastByte = cyc;
        if (pkt.size() == 3) begin
          h = pkt[0];
          mBtn  = h[1:0];
          mSign = {h[4], h[5]};
          mX    = axis(pkt[1], h[4], h[6]);
          mY    = axis(pkt[2], h[5], h[7]);
          if (prevDav) begin
            davStart = cyc + 1; davEnd = cyc + DAV;
          end else begin
            davStart = cyc; davEnd = cyc + DAV - 1;
          end
          pkt.delete();
        end
      end
    end else if (pkt.size() > 0 && (cyc - lastByte) >= TIMEOUT) begin
      pkt.delete();
      mPerr = 1'b1;
    end
  endtask

  task automatic checkOutput();
    logic [21:0] got, exp;
    logic        expDav;
    expDav = (cyc >= davStart) && (cyc <= davEnd);
    got = {button, sign, mousexdata, mouseydata, dav, perr};
    exp = {mBtn, mSign, mX, mY, expDav, mPerr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL cycle %0d: got btn/sign/x/y/dav/perr=%h expected %h", cyc, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic e, input logic [7:0] b);
    reset = r; rxvalid = v; rxerror = e; rxbyte = b;
    @(posedge clock);
    cyc++;
    modelStep(r, v, e, b);
    #1;
    checkOutput();
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, 1'b0, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int         cnt;
    logic       r, v, e;
    logic [7:0] b;

    tbl[0] = '{8'h08, 8'h05, 8'hFD, 2'b00, 2'b00, 8'h05, 8'hFD};
    tbl[1] = '{8'h39, 8'hFB, 8'h02, 2'b01, 2'b11, 8'hFB, 8'h02};
    tbl[2] = '{8'h58, 8'h00, 8'h10, 2'b00, 2'b10, 8'h01, 8'h10};
    tbl[3] = '{8'h88, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 8'hFF};
    tbl[4] = '{8'h28, 8'h12, 8'h00, 2'b00, 2'b01, 8'h12, 8'h01};
    tbl[5] = '{8'h1B, 8'h00, 8'h7F, 2'b11, 2'b10, 8'h01, 8'h7F};
    tbl[6] = '{8'hF8, 8'h33, 8'h44, 2'b00, 2'b11, 8'h01, 8'h01};
    tbl[7] = '{8'h0A, 8'h80, 8'h80, 2'b10, 2'b00, 8'h80, 8'h80};

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("reset_outputs", {button, sign, mousexdata, mouseydata, dav, perr}, 32'h0);
    idle(2);

    foreach (tbl[i]) begin
      sendByte(tbl[i].b0);
      idle(1);
      sendByte(tbl[i].b1);
      sendByte(tbl[i].b2);
      checkValue($sformatf("tbl%0d_btn", i), button, tbl[i].btn);
      checkValue($sformatf("tbl%0d_sign", i), sign, tbl[i].sgn);
      checkValue($sformatf("tbl%0d_x", i), mousexdata, tbl[i].x);
      checkValue($sformatf("tbl%0d_y", i), mouseydata, tbl[i].y);
      cnt = 1;
      for (int k = 0; k < DAV + 3; k++) begin
        idle(1);
        if (dav) cnt++;
      end
      checkValue($sformatf("tbl%0d_davlen", i), cnt, DAV);
    end

    // Byte without bit3 in IDLE_B0 is a resync error, then a clean packet
    sendByte(8'h03);
    checkValue("resync_perr", perr, 1);
    sendByte(8'h08); sendByte(8'h05); sendByte(8'hFD);
    checkValue("resync_packet_y", mouseydata, 8'hFD);
    idle(DAV + 2);

    // Inter-byte timeout
    sendByte(8'h08); sendByte(8'h05);
    cnt = 0;
    for (int k = 0; k < TIMEOUT + 3; k++) begin
      idle(1);
      if (perr) cnt++;
    end
    checkValue("timeout_perr_count", cnt, 1);
    sendByte(8'h08); sendByte(8'h01); sendByte(8'h01);
    checkValue("after_timeout_xy", {mousexdata, mouseydata}, 16'h0101);
    idle(DAV + 2);

    // rxerror on byte1, with a coincident rxvalid
    sendByte(8'h09);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h22);
    checkValue("rxerr_perr", perr, 1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      if (dav) cnt++;
    end
    checkValue("rxerr_no_dav", cnt, 0);
    checkValue("rxerr_outputs_held", {mousexdata, mouseydata}, 16'h0101);

    // Back-to-back packets: dav low one clock between periods
    sendByte(8'h08); sendByte(8'h11); sendByte(8'h22);
    sendByte(8'h09); sendByte(8'h33); sendByte(8'h44);
    checkValue("b2b_dav_gap", dav, 0);
    checkValue("b2b_new_data", {mousexdata, mouseydata}, 16'h3344);
    cnt = 0;
    for (int k = 0; k < DAV + 4; k++) begin
      idle(1);
      if (dav) cnt++;
    end
    checkValue("b2b_second_len", cnt, DAV);

    // Reset during GET_B2 with dav high
    sendByte(8'h0B); sendByte(8'h12); sendByte(8'h34);
    sendByte(8'h08); sendByte(8'h05);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("rst_midpacket", {button, sign, mousexdata, mouseydata, dav, perr}, 32'h0);
    sendByte(8'h08); sendByte(8'h05); sendByte(8'hFD);
    checkValue("rst_then_packet", {mousexdata, mouseydata, dav}, {16'h05FD, 1'b1});
    idle(DAV + 2);

    // rxvalid coincident with reset is dropped, so the next byte is out of sync
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h08);
    sendByte(8'h05);
    checkValue("rst_valid_ignored", perr, 1);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) idle($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 2) == 0);
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b[3] = 1'b1;
      applyStimulus(r, v, e, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
